// File: rtl/a10s_stream_pkg.sv
// Shared definitions for the HPS stream command responder: opcodes,
// status codes, header field positions, FSM state type and a status helper.
package a10s_stream_pkg;

  localparam logic [7:0] OP_ECHO   = 8'h01;
  localparam logic [7:0] OP_INVERT = 8'h02;
  localparam logic [7:0] OP_SUM    = 8'h03;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_OP   = 8'h01;
  localparam logic [7:0] ST_TOO_LONG = 8'h02;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  // An unknown opcode outranks an oversize length.
  function automatic logic [7:0] calc_status(input logic [7:0] op, input logic too_long);
    logic [7:0] st;
    case (op)
      OP_ECHO, OP_INVERT, OP_SUM: st = too_long ? ST_TOO_LONG : ST_OK;
      default:                    st = ST_BAD_OP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/a10s_st_cmd_responder_if.sv
// Avalon-ST (readyLatency 0) link: master drives data/valid, slave drives ready.
interface a10s_st_if #(parameter int DATA_W = 32) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/a10s_st_out_reg.sv
// One-entry Avalon-ST output register. Holds a word until the downstream
// accepts it; the caller may load only while free is high.
module a10s_st_out_reg
  import a10s_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              free,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;

  // Load a new word, or drop valid once the current word is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else if (valid_r && src_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign free      = !valid_r || src_ready;
  assign src_data  = data_r;
  assign src_valid = valid_r;

endmodule

// File: rtl/a10s_st_cmd_responder.sv
// Fabric-side responder: consumes command packets from the HPS->FPGA FIFO
// and emits header/payload/trailer response packets to the FPGA->HPS FIFO.
module a10s_st_cmd_responder
  import a10s_stream_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1024
) (
  input  logic        clk_100_clk,
  input  logic        reset_reset_n,
  a10s_st_if.slave    snk,
  a10s_st_if.master   src,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  state_t             state_r, state_nxt_s;
  logic [7:0]         op_r, status_r;
  logic [LEN_W-1:0]   n_r, cnt_r;
  logic [DATA_W-1:0]  sum_r;
  logic [15:0]        pkt_r;
  logic [7:0]         err_r;

  logic               free_s, load_s, snk_ready_s, accept_s, last_s;
  logic [DATA_W-1:0]  load_data_s;
  logic [7:0]         hdr_op_s, hdr_status_s;
  logic [LEN_W-1:0]   hdr_n_s;
  logic               hdr_too_long_s;
  logic [15:0]        hdr_rlen_s;
  logic [LEN_W:0]     cnt_inc_s;

  // Header decode, valid only while a header word is presented in IDLE.
  assign hdr_op_s       = snk.data[OP_MSB:OP_LSB];
  assign hdr_n_s        = snk.data[LEN_W-1:0];
  assign hdr_too_long_s = 32'(hdr_n_s) > 32'(MAX_LEN);
  assign hdr_status_s   = calc_status(hdr_op_s, hdr_too_long_s);
  assign hdr_rlen_s     = (hdr_status_s == ST_OK && hdr_op_s != OP_SUM) ? 16'(hdr_n_s) : 16'h0000;

  // One extra bit so a full 2^LEN_W-1 drain cannot wrap the compare.
  assign cnt_inc_s = {1'b0, cnt_r} + (LEN_W + 1)'(1);
  assign last_s    = (cnt_inc_s == {1'b0, n_r});

  assign accept_s  = snk.valid && snk_ready_s;
  assign snk.ready = snk_ready_s && reset_reset_n;
  assign busy      = (state_r != S_IDLE) || src.valid;
  assign pkt_count = pkt_r;
  assign err_count = err_r;

  // Next-state, sink ready and output-register load decisions.
  always_comb begin
    state_nxt_s = state_r;
    snk_ready_s = 1'b0;
    load_s      = 1'b0;
    load_data_s = 32'h0000_0000;
    case (state_r)
      S_IDLE: begin
        snk_ready_s = free_s;
        if (snk.valid && free_s) begin
          load_s      = 1'b1;
          load_data_s = {hdr_op_s, hdr_status_s, hdr_rlen_s};
          if (hdr_n_s == '0) begin
            state_nxt_s = S_TRAIL;
          end else if (hdr_status_s != ST_OK) begin
            state_nxt_s = S_DRAIN;
          end else if (hdr_op_s == OP_SUM) begin
            state_nxt_s = S_ACC;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DATA: begin
        snk_ready_s = free_s;
        if (snk.valid && free_s) begin
          load_s      = 1'b1;
          load_data_s = (op_r == OP_INVERT) ? ~snk.data : snk.data;
          state_nxt_s = last_s ? S_TRAIL : S_DATA;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_ACC, S_DRAIN: begin
        snk_ready_s = 1'b1;
        if (snk.valid && last_s) begin
          state_nxt_s = S_TRAIL;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_TRAIL: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = (status_r == ST_OK) ? sum_r : 32'h0000_0000;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_TRAIL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, packet context, word counter, checksum and statistics.
  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      state_r  <= S_IDLE;
      op_r     <= 8'h00;
      status_r <= 8'h00;
      n_r      <= '0;
      cnt_r    <= '0;
      sum_r    <= 32'h0000_0000;
      pkt_r    <= 16'h0000;
      err_r    <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r     <= hdr_op_s;
            status_r <= hdr_status_s;
            n_r      <= hdr_n_s;
            cnt_r    <= '0;
            sum_r    <= 32'h0000_0000;
          end
        end
        S_DATA, S_ACC: begin
          if (accept_s) begin
            sum_r <= sum_r + snk.data;
            cnt_r <= cnt_r + LEN_W'(1);
          end
        end
        S_DRAIN: begin
          if (accept_s) begin
            cnt_r <= cnt_r + LEN_W'(1);
          end
        end
        S_TRAIL: begin
          if (load_s) begin
            pkt_r <= pkt_r + 16'h0001;
            if (status_r != ST_OK && err_r != 8'hFF) begin
              err_r <= err_r + 8'h01;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  a10s_st_out_reg u_out_reg (
    .clk       (clk_100_clk),
    .rst_n     (reset_reset_n),
    .load      (load_s),
    .load_data (load_data_s),
    .free      (free_s),
    .src_data  (src.data),
    .src_valid (src.valid),
    .src_ready (src.ready)
  );

endmodule

// File: tb/tb_a10s_st_cmd_responder.sv
// Directed bench for a10s_st_cmd_responder: drives command packets, records
// every accepted response word and compares against hand-computed packets.
module tb_a10s_st_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  a10s_st_if cmd ();
  a10s_st_if rsp ();

  a10s_st_cmd_responder dut (
    .clk_100_clk   (clk),
    .reset_reset_n (rst_n),
    .snk           (cmd),
    .src           (rsp),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  bit          toggle_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] data_prev = 32'h0;
  logic [31:0] sum5;
  logic [31:0] words5[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Toggle response backpressure every cycle when enabled.
  always @(negedge clk) begin
    if (toggle_en) rsp.ready = ~rsp.ready;
  end

  // Record words that will transfer on the next rising edge; check hold under stall.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", {31'h0, rsp.valid}, 32'h1);
        chk("hold_data", rsp.data, data_prev);
      end
      if (rsp.valid && rsp.ready) rsp_q.push_back(rsp.data);
      stall_prev = rsp.valid && !rsp.ready;
      data_prev  = rsp.data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    cmd.valid = 1'b1;
    cmd.data  = w;
    t = 0;
    #1;
    while (!cmd.ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("snk_ready_timeout", 32'h0, 32'h1);
    @(posedge clk);
    @(negedge clk);
    cmd.valid = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    int t;
    t = 0;
    while (rsp_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_len"}, rsp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), (i < rsp_q.size()) ? rsp_q[i] : 32'hXXXX_XXXX, exp_q[i]);
    end
    rsp_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd.valid = 1'b0;
    cmd.data  = 32'h0;
    rsp.ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_src_valid", {31'h0, rsp.valid}, 32'h0);
    chk("rst_src_data", rsp.data, 32'h0);
    chk("rst_snk_ready", {31'h0, cmd.ready}, 32'h0);
    chk("rst_pkt_count", {16'h0, pkt_count}, 32'h0);
    chk("rst_err_count", {24'h0, err_count}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_snk_ready", {31'h0, cmd.ready}, 32'h1);

    // 1: ECHO N=3
    send(32'h0100_0003, 0); send(32'h1, 0); send(32'h2, 0); send(32'h3, 0);
    exp_q = '{32'h0100_0003, 32'h1, 32'h2, 32'h3, 32'h6};
    check_pkt("echo");
    chk("echo_pkt_count", {16'h0, pkt_count}, 32'd1);
    chk("echo_err_count", {24'h0, err_count}, 32'd0);

    // 2: INVERT N=2
    send(32'h0200_0002, 0); send(32'h0000_0000, 0); send(32'hFFFF_0000, 0);
    exp_q = '{32'h0200_0002, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};
    check_pkt("invert");

    // 3: SUM N=2 with output stalled: payload still accepted
    rsp.ready = 1'b0;
    send(32'h0300_0002, 0);
    #1;
    chk("sum_snk_ready_w0", {31'h0, cmd.ready}, 32'h1);
    send(32'hFFFF_FFFF, 0);
    #1;
    chk("sum_snk_ready_w1", {31'h0, cmd.ready}, 32'h1);
    send(32'h0000_0002, 0);
    rsp.ready = 1'b1;
    exp_q = '{32'h0300_0000, 32'h0000_0001};
    check_pkt("sum");

    // 4: bad opcode drained, then oversize ECHO drained
    send(32'h7F00_0004, 0);
    for (int i = 0; i < 4; i++) send(32'hA000_0000 + i, 0);
    exp_q = '{32'h7F01_0000, 32'h0};
    check_pkt("badop");
    send(32'h0100_07D0, 0);
    for (int i = 0; i < 2000; i++) send(i, 0);
    exp_q = '{32'h0102_0000, 32'h0};
    check_pkt("toolong");
    chk("err_pkt_count", {16'h0, pkt_count}, 32'd5);
    chk("err_err_count", {24'h0, err_count}, 32'd2);

    // 5: ECHO N=4 under toggling backpressure and source gaps
    words5 = '{32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0F0F_0F0F};
    sum5   = 32'h7FF1_2477;
    toggle_en = 1'b1;
    send(32'h0100_0004, 1);
    for (int i = 0; i < 4; i++) send(words5[i], int'($urandom_range(0, 2)));
    exp_q = '{32'h0100_0004, words5[0], words5[1], words5[2], words5[3], sum5};
    check_pkt("bp");
    toggle_en = 1'b0;
    @(negedge clk);
    rsp.ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_pkt_count", {16'h0, pkt_count}, 32'd6);

    // 6: reset mid-packet, then fresh ECHO N=0
    send(32'h0100_0005, 0); send(32'h11, 0); send(32'h22, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_src_valid", {31'h0, rsp.valid}, 32'h0);
    chk("mid_rst_pkt_count", {16'h0, pkt_count}, 32'h0);
    chk("mid_rst_err_count", {24'h0, err_count}, 32'h0);
    chk("mid_rst_snk_ready", {31'h0, cmd.ready}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_q.delete();
    send(32'h0100_0000, 0);
    exp_q = '{32'h0100_0000, 32'h0};
    check_pkt("post_rst");
    chk("post_rst_pkt_count", {16'h0, pkt_count}, 32'd1);
    chk("post_rst_err_count", {24'h0, err_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
